atconv_layer_mem: RTL

//  Memory-side responder for the ATCONV layer-memory interface (cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, csel).

---
 rtl/atconv_pkg.sv | 20 ++
 rtl/atconv_sp_bank.sv | 22 ++
 rtl/atconv_layer_mem.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/atconv_pkg.sv
// Shared constants and types for the ATCONV layer memory.
package atconv_pkg;
  localparam int DATA_W   = 13;
  localparam int ADDR_W   = 12;
  localparam int L0_DEPTH = 4096;
  localparam int L1_DEPTH = 1024;
  localparam int L0_LAST  = L0_DEPTH - 1;
  localparam int L1_LAST  = L1_DEPTH - 1;
  localparam int L0_AW    = $clog2(L0_DEPTH);
  localparam int L1_AW    = $clog2(L1_DEPTH);

  typedef enum logic [2:0] {
    IDLE, FETCH, PRESENT, DONE, CLEAR
  } dump_state_t;

  // Source of the word presented on cdata_rd after a host read.
  typedef enum logic [1:0] {
    RD_B0, RD_B1, RD_BYP, RD_ZERO
  } rd_src_t;
endpackage

// File: rtl/atconv_sp_bank.sv
// Single-port-style bank: one synchronous write port, one registered read port.
// Read returns the old contents on a same-address write; the top handles bypass.
module atconv_sp_bank #(
  parameter int DEPTH = 1024,
  parameter int DW    = 13
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Storage and read register; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/atconv_layer_mem.sv
// ATCONV layer memory responder: L0/L1 banks, host read/write, post-run dump.
// Optional feature: define ATCONV_MEM_CLEAR_EN to zero both banks after reset.
module atconv_layer_mem
  import atconv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              busy,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic              csel,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_bank,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic              oob_err,
  output logic              init_done
);
  dump_state_t       state_q, state_d;
  logic              dbank_d;
  logic [ADDR_W-1:0] daddr_d;
  logic              busy_q;
  logic              clearing;
  logic [L0_AW-1:0]  clr_addr;

  logic              wr_oob, rd_oob, host_wr_ok, dump_own;
  logic              we0, we1, re0, re1;
  logic [L0_AW-1:0]  waddr0, raddr0;
  logic [L1_AW-1:0]  waddr1, raddr1;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1;

  logic              rd_pend_q;
  rd_src_t           rd_src_q;
  logic [DATA_W-1:0] byp_q, hold_q;

`ifdef ATCONV_MEM_CLEAR_EN
  localparam dump_state_t RST_STATE = CLEAR;
  logic [L0_AW-1:0] clr_q;
  assign clearing  = (state_q == CLEAR);
  assign clr_addr  = clr_q;
  assign init_done = ~clearing;

  // Clear address counter walks L0 once; L1 is covered by the low quarter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      clr_q <= '0;
    else if (clearing) clr_q <= clr_q + 1'b1;
  end
`else
  localparam dump_state_t RST_STATE = IDLE;
  logic init_q;
  assign clearing  = 1'b0;
  assign clr_addr  = '0;
  assign init_done = init_q;

  // Banks are usable from the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) init_q <= 1'b0;
    else          init_q <= 1'b1;
  end
`endif

  // L1 accesses past its depth are dropped (write) or return zero (read).
  assign wr_oob     = csel & (caddr_wr >= ADDR_W'(L1_DEPTH));
  assign rd_oob     = csel & (caddr_rd >= ADDR_W'(L1_DEPTH));
  assign host_wr_ok = cwr & ~clearing & ~wr_oob;
  assign dump_own   = (state_q == FETCH) || (state_q == PRESENT);

  assign we0    = clearing | (host_wr_ok & ~csel);
  assign waddr0 = clearing ? clr_addr : caddr_wr;
  assign wdata0 = clearing ? '0 : cdata_wr;
  assign we1    = (clearing & (clr_addr < L0_AW'(L1_DEPTH))) | (host_wr_ok & csel);
  assign waddr1 = clearing ? clr_addr[L1_AW-1:0] : caddr_wr[L1_AW-1:0];
  assign wdata1 = clearing ? '0 : cdata_wr;

  // Dump owns the read port of the bank it is streaming.
  assign re0    = (dump_own & ~dump_bank) | (crd & ~csel);
  assign raddr0 = (dump_own & ~dump_bank) ? dump_addr : caddr_rd;
  assign re1    = (dump_own & dump_bank) | (crd & csel & ~rd_oob);
  assign raddr1 = (dump_own & dump_bank) ? dump_addr[L1_AW-1:0] : caddr_rd[L1_AW-1:0];

  atconv_sp_bank #(.DEPTH(L0_DEPTH), .DW(DATA_W)) u_bank0 (
    .clk(clk), .we(we0), .waddr(waddr0), .wdata(wdata0),
    .re(re0), .raddr(raddr0), .rdata(rdata0)
  );

  atconv_sp_bank #(.DEPTH(L1_DEPTH), .DW(DATA_W)) u_bank1 (
    .clk(clk), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .re(re1), .raddr(raddr1), .rdata(rdata1)
  );

  // Remember where the host read's answer comes from; hold the last answer otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_src_q  <= RD_ZERO;
      byp_q     <= '0;
      hold_q    <= '0;
    end else begin
      hold_q    <= cdata_rd;
      rd_pend_q <= crd;
      if (crd) begin
        byp_q <= cdata_wr;
        if (rd_oob)                                    rd_src_q <= RD_ZERO;
        else if (host_wr_ok && caddr_wr == caddr_rd)   rd_src_q <= RD_BYP;
        else                                           rd_src_q <= csel ? RD_B1 : RD_B0;
      end
    end
  end

  // Host read data: fresh word the cycle after crd, held value otherwise.
  always_comb begin
    cdata_rd = hold_q;
    if (rd_pend_q) begin
      unique case (rd_src_q)
        RD_B0:   cdata_rd = rdata0;
        RD_B1:   cdata_rd = rdata1;
        RD_BYP:  cdata_rd = byp_q;
        default: cdata_rd = '0;
      endcase
    end
  end

  // Sticky out-of-range flag for L1 accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  oob_err <= 1'b0;
    else if ((cwr & wr_oob) | (crd & rd_oob))      oob_err <= 1'b1;
  end

  // Dump FSM state and cursor registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      busy_q    <= 1'b0;
      dump_bank <= 1'b0;
      dump_addr <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy;
      dump_bank <= dbank_d;
      dump_addr <= daddr_d;
    end
  end

  // Dump FSM next-state: fetch/present per word, L0 then L1, abort on busy.
  always_comb begin
    state_d = state_q;
    dbank_d = dump_bank;
    daddr_d = dump_addr;
    unique case (state_q)
      IDLE: if (busy_q && !busy) begin
        state_d = FETCH;
        dbank_d = 1'b0;
        daddr_d = '0;
      end
      FETCH: state_d = busy ? IDLE : PRESENT;
      PRESENT: begin
        if (busy) state_d = IDLE;
        else if (dump_ready) begin
          if (!dump_bank && dump_addr == ADDR_W'(L0_LAST)) begin
            state_d = FETCH;
            dbank_d = 1'b1;
            daddr_d = '0;
          end else if (dump_bank && dump_addr == ADDR_W'(L1_LAST)) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            daddr_d = dump_addr + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      CLEAR:   if (clr_addr == L0_AW'(L0_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dump_valid = (state_q == PRESENT);
  assign dump_done  = (state_q == DONE);
  assign dump_data  = dump_valid ? (dump_bank ? rdata1 : rdata0) : '0;
endmodule
